// File: rtl/experiment3_pkg.sv
// Shared constants and result payload for the experiment3 adder collection.
package experiment3_pkg;

    // Default A/B datapath width and the four-bit adder operand width.
    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned NIBBLE_W  = 4;

    // Registered results of the one-bit and four-bit adders.
    typedef struct packed {
        logic                ha_c;
        logic                ha_s;
        logic                fa_c;
        logic                fa_s;
        logic                fb_c;
        logic [NIBBLE_W-1:0] fb_s;
    } small_res_t;

endpackage : experiment3_pkg

// File: rtl/full_adder.sv
// One-bit full adder; the only cell used to build every ripple chain in experiment3.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/experiment3.sv
// Registered collection of ripple-carry adders: half, full, four-bit, WIDTH-bit
// add, WIDTH-bit subtract and a selectable add/subtract ("part7") with overflow flag.
// Optional feature macro: OVERFLOW_FLAG_EN (when undefined, flag is tied to 0).
module experiment3
    import experiment3_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [NIBBLE_W-1:0] M,
    input  logic [NIBBLE_W-1:0] N,
    input  logic                Cin,
    input  logic                X,
    input  logic                Y,
    input  logic                Sign,
    output logic                flag,
    output logic                halfadderout,
    output logic                halfadderoutput,
    output logic                fulladderout,
    output logic                fulladderoutput,
    output logic                fourbitadderout,
    output logic [NIBBLE_W-1:0] fourbitoutput,
    output logic                sixteenOut,
    output logic [WIDTH-1:0]    sixteenOutput,
    output logic                sixteensubtOut,
    output logic [WIDTH-1:0]    sixteensubtOutput,
    output logic                part7Out,
    output logic [WIDTH-1:0]    part7Output
);

    // Combinational adder results
    logic                ha_s;
    logic                ha_c;
    logic                fa_s;
    logic                fa_c;
    logic [NIBBLE_W:0]   fb_c;
    logic [NIBBLE_W-1:0] fb_s;
    logic [WIDTH:0]      add_c;
    logic [WIDTH-1:0]    add_s;
    logic [WIDTH-1:0]    sub_b;
    logic [WIDTH:0]      sub_c;
    logic [WIDTH-1:0]    sub_s;
    logic [WIDTH-1:0]    p7_b;
    logic [WIDTH:0]      p7_c;
    logic [WIDTH-1:0]    p7_s;

    // Registered state
    small_res_t          small_d;
    small_res_t          small_q;
    logic [WIDTH:0]      add_d;
    logic [WIDTH:0]      add_q;
    logic [WIDTH:0]      sub_d;
    logic [WIDTH:0]      sub_q;
    logic [WIDTH:0]      p7_d;
    logic [WIDTH:0]      p7_q;
    logic                flag_d;
    logic                flag_q;

    // Half adder is a full adder with carry-in held low.
    full_adder u_ha (.a(X), .b(Y), .cin(1'b0), .sum(ha_s), .cout(ha_c));

    full_adder u_fa (.a(X), .b(Y), .cin(Cin), .sum(fa_s), .cout(fa_c));

    // Subtraction is A + ~B + 1; part7 selects between add and subtract via Sign.
    assign sub_b    = ~B;
    assign p7_b     = B ^ {WIDTH{Sign}};
    assign fb_c[0]  = Cin;
    assign add_c[0] = 1'b0;
    assign sub_c[0] = 1'b1;
    assign p7_c[0]  = Sign;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fb
        full_adder u_fa (
            .a(M[i]), .b(N[i]), .cin(fb_c[i]), .sum(fb_s[i]), .cout(fb_c[i+1])
        );
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_wide
        full_adder u_add (
            .a(A[i]), .b(B[i]), .cin(add_c[i]), .sum(add_s[i]), .cout(add_c[i+1])
        );
        full_adder u_sub (
            .a(A[i]), .b(sub_b[i]), .cin(sub_c[i]), .sum(sub_s[i]), .cout(sub_c[i+1])
        );
        full_adder u_p7 (
            .a(A[i]), .b(p7_b[i]), .cin(p7_c[i]), .sum(p7_s[i]), .cout(p7_c[i+1])
        );
    end

    // Gather next-state values; overflow uses the effective (possibly inverted) B operand.
    always_comb begin
        small_d      = '0;
        small_d.ha_c = ha_c;
        small_d.ha_s = ha_s;
        small_d.fa_c = fa_c;
        small_d.fa_s = fa_s;
        small_d.fb_c = fb_c[NIBBLE_W];
        small_d.fb_s = fb_s;
        add_d        = {add_c[WIDTH], add_s};
        sub_d        = {sub_c[WIDTH], sub_s};
        p7_d         = {p7_c[WIDTH], p7_s};
`ifdef OVERFLOW_FLAG_EN
        flag_d       = (A[WIDTH-1] == p7_b[WIDTH-1]) && (p7_s[WIDTH-1] != A[WIDTH-1]);
`else
        flag_d       = 1'b0;
`endif
    end

    // Output registers with synchronous reset that overrides any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            small_q <= '0;
            add_q   <= '0;
            sub_q   <= '0;
            p7_q    <= '0;
            flag_q  <= 1'b0;
        end else begin
            small_q <= small_d;
            add_q   <= add_d;
            sub_q   <= sub_d;
            p7_q    <= p7_d;
            flag_q  <= flag_d;
        end
    end

    assign halfadderout      = small_q.ha_c;
    assign halfadderoutput   = small_q.ha_s;
    assign fulladderout      = small_q.fa_c;
    assign fulladderoutput   = small_q.fa_s;
    assign fourbitadderout   = small_q.fb_c;
    assign fourbitoutput     = small_q.fb_s;
    assign sixteenOut        = add_q[WIDTH];
    assign sixteenOutput     = add_q[WIDTH-1:0];
    assign sixteensubtOut    = sub_q[WIDTH];
    assign sixteensubtOutput = sub_q[WIDTH-1:0];
    assign part7Out          = p7_q[WIDTH];
    assign part7Output       = p7_q[WIDTH-1:0];
    assign flag              = flag_q;

endmodule : experiment3

// File: tb/tb_experiment3.sv
// Directed + random bench for experiment3 with an expected-result queue.
module tb_experiment3;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W:0] sum;
        logic [W:0] diff;
        logic [W:0] p7;
        logic       flag;
        logic [1:0] ha;
        logic [1:0] fa;
        logic [4:0] fb;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   M = '0;
    logic [3:0]   N = '0;
    logic         Cin = 1'b0;
    logic         X = 1'b0;
    logic         Y = 1'b0;
    logic         Sign = 1'b0;
    logic         flag;
    logic         halfadderout, halfadderoutput;
    logic         fulladderout, fulladderoutput;
    logic         fourbitadderout;
    logic [3:0]   fourbitoutput;
    logic         sixteenOut;
    logic [W-1:0] sixteenOutput;
    logic         sixteensubtOut;
    logic [W-1:0] sixteensubtOutput;
    logic         part7Out;
    logic [W-1:0] part7Output;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    experiment3 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .M(M), .N(N), .Cin(Cin),
        .X(X), .Y(Y), .Sign(Sign), .flag(flag),
        .halfadderout(halfadderout), .halfadderoutput(halfadderoutput),
        .fulladderout(fulladderout), .fulladderoutput(fulladderoutput),
        .fourbitadderout(fourbitadderout), .fourbitoutput(fourbitoutput),
        .sixteenOut(sixteenOut), .sixteenOutput(sixteenOutput),
        .sixteensubtOut(sixteensubtOut), .sixteensubtOutput(sixteensubtOutput),
        .part7Out(part7Out), .part7Output(part7Output)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Arithmetic reference using integer math, independent of bit-level structure.
    function automatic exp_t model(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] m, input logic [3:0] n, input logic ci,
                                   input logic x, input logic y, input logic sg);
        exp_t e;
        int   sa, sb_i, res;
        e.sum  = (W+1)'(int'(a) + int'(b));
        e.diff = (W+1)'(int'(a) + (65535 - int'(b)) + 1);
        e.p7   = sg ? e.diff : e.sum;
        sa     = int'($signed(a));
        sb_i   = int'($signed(b));
        res    = sg ? (sa - sb_i) : (sa + sb_i);
`ifdef OVERFLOW_FLAG_EN
        e.flag = (res > 32767) || (res < -32768);
`else
        e.flag = 1'b0;
`endif
        e.ha = 2'(int'(x) + int'(y));
        e.fa = 2'(int'(x) + int'(y) + int'(ci));
        e.fb = 5'(int'(m) + int'(n) + int'(ci));
        if (r) begin
            e = '{sum: '0, diff: '0, p7: '0, flag: 1'b0, ha: '0, fa: '0, fb: '0};
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, record the expectation, then compare after the edge.
    task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] m, input logic [3:0] n, input logic ci,
                        input logic x, input logic y, input logic sg);
        exp_t e;
        rst = r; A = a; B = b; M = m; N = n; Cin = ci; X = x; Y = y; Sign = sg;
        sb.push_back(model(r, a, b, m, n, ci, x, y, sg));
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed %0d expected 1", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sum",  {sixteenOut, sixteenOutput}, e.sum);
            check("diff", {sixteensubtOut, sixteensubtOutput}, e.diff);
            check("part7", {part7Out, part7Output}, e.p7);
            check("flag", (W+1)'(flag), (W+1)'(e.flag));
            check("half", (W+1)'({halfadderout, halfadderoutput}), (W+1)'(e.ha));
            check("full", (W+1)'({fulladderout, fulladderoutput}), (W+1)'(e.fa));
            check("fourbit", (W+1)'({fourbitadderout, fourbitoutput}), (W+1)'(e.fb));
        end
    endtask

    initial begin
        @(negedge clk);
        // Reset state, with nonzero inputs present
        step(1'b1, 16'd5, 16'd9, 4'd3, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 16'd0, 16'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Directed vectors from the requirements
        step(1'b0, 16'd29,  16'd3,   4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("req030_sum_const", {sixteenOut, sixteenOutput}, 17'd32);
        step(1'b0, 16'd103, 16'd145, 4'd5, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        check("req031_p7_const", {part7Out, part7Output}, 17'h0FFD6);
        step(1'b0, 16'd202, 16'd97,  4'd7, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'd21,  16'd83,  4'd2, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        check("req032_p7_const", {part7Out, part7Output}, 17'h0FFC2);
        // Signed overflow and four-bit carry-out boundary
        step(1'b0, 16'h7FFF, 16'd1,  4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0);
        check("req033_fb_const", (W+1)'({fourbitadderout, fourbitoutput}), 17'h0001F);
        step(1'b0, 16'h8000, 16'd1,  4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'hFFFF, 16'hFFFF, 4'd15, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'd0,    16'd0,    4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Reset mid-stream overrides in-flight operation, then recovery
        step(1'b1, 16'h1234, 16'h0FED, 4'd9, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 16'h1234, 16'h0FED, 4'd9, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1);
        // Random sweep
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_experiment3
